// File: rtl/imgproc_pkg.sv
// Shared constants for the camera pixel-processing path.
//   - Luma weights (BT.601 style, scaled by 256): 77 / 150 / 29
//   - Default active image size
//   - Pipeline depth from input strobe to output
//   - Bundle type for the frame/line/pixel strobes
package imgproc_pkg;

  localparam int unsigned COEF_R    = 77;
  localparam int unsigned COEF_G    = 150;
  localparam int unsigned COEF_B    = 29;

  localparam int unsigned IMG_W_DEF = 640;
  localparam int unsigned IMG_H_DEF = 480;

  localparam int unsigned STAGES    = 3;

  localparam int unsigned DATA_W    = 16;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

endpackage

// File: rtl/rgb565_to_y.sv
// RGB565 to weighted-sum luma core.
// Expands each channel to 8 bits, then runs a two-stage pipeline:
//   p1: the three coefficient products, p2: their 16-bit sum.
// Luma is the upper byte of the sum; the caller takes it from o_sum_p2.
// Ports:
//   i_clk     pixel clock
//   i_rst_n   synchronous active-low reset
//   i_vld_p0  pixel strobe aligned with i_pix_p0
//   i_vld_p1  the same strobe delayed one cycle (owned by the caller)
//   i_pix_p0  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
//   o_sum_p2  77*R8 + 150*G8 + 29*B8, held between valid pixels
module rgb565_to_y
  import imgproc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_vld_p0,
  input  logic              i_vld_p1,
  input  logic [DATA_W-1:0] i_pix_p0,
  output logic [15:0]       o_sum_p2
);

  // Bit replication keeps full-scale inputs at full scale (31 -> 255, 63 -> 255).
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

  logic [7:0]  w_r8_p0;
  logic [7:0]  w_g8_p0;
  logic [7:0]  w_b8_p0;
  logic [14:0] w_prod_r_p0;
  logic [15:0] w_prod_g_p0;
  logic [14:0] w_prod_b_p0;
  logic [15:0] w_sum_p1;

  logic [14:0] r_prod_r_p1;
  logic [15:0] r_prod_g_p1;
  logic [14:0] r_prod_b_p1;
  logic [15:0] r_sum_p2;

  assign w_r8_p0     = expand5(i_pix_p0[15:11]);
  assign w_g8_p0     = expand6(i_pix_p0[10:5]);
  assign w_b8_p0     = expand5(i_pix_p0[4:0]);

  assign w_prod_r_p0 = 15'(w_r8_p0) * 15'(COEF_R);
  assign w_prod_g_p0 = 16'(w_g8_p0) * 16'(COEF_G);
  assign w_prod_b_p0 = 15'(w_b8_p0) * 15'(COEF_B);

  // ---- stage p0 -> p1: products ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prod_r_p1 <= '0;
      r_prod_g_p1 <= '0;
      r_prod_b_p1 <= '0;
    end else if (i_vld_p0) begin
      r_prod_r_p1 <= w_prod_r_p0;
      r_prod_g_p1 <= w_prod_g_p0;
      r_prod_b_p1 <= w_prod_b_p0;
    end
  end

  // Weights add to 256, so the sum peaks at 255*256 = 65280 and never wraps.
  assign w_sum_p1 = 16'(r_prod_r_p1) + r_prod_g_p1 + 16'(r_prod_b_p1);

  // ---- stage p1 -> p2: sum ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum_p2 <= '0;
    end else if (i_vld_p1) begin
      r_sum_p2 <= w_sum_p1;
    end
  end

  assign o_sum_p2 = r_sum_p2;

endmodule

// File: rtl/rgb565_gray_binarize.sv
// Camera pixel stage: RGB565 -> 8-bit luma, thresholded bit and pixel
// coordinates, all aligned three cycles behind the input strobes.
// Ports:
//   cam_pclk          pixel clock (only clock)
//   rst_n             synchronous active-low reset
//   pre_frame_vsync   frame sync from capture
//   pre_frame_href    line valid from capture
//   pre_frame_clken   one-cycle pixel strobe
//   pre_img_data      RGB565 pixel, valid with pre_frame_clken
//   bin_threshold     luma threshold, captured at each frame start
//   post_frame_vsync  vsync delayed 3 cycles
//   post_frame_href   href delayed 3 cycles
//   post_frame_clken  clken delayed 3 cycles
//   post_img_y        luma of presented pixel
//   post_img_bit      1 when post_img_y exceeds the frame threshold
//   post_pixel_x      column of presented pixel (saturates at IMG_W-1)
//   post_pixel_y      row of presented pixel (saturates at IMG_H-1)
// Pixel outputs are valid with post_frame_clken and hold otherwise.
module rgb565_gray_binarize
  import imgproc_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int X_W   = 10,
  parameter int Y_W   = 10
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              pre_frame_vsync,
  input  logic              pre_frame_href,
  input  logic              pre_frame_clken,
  input  logic [DATA_W-1:0] pre_img_data,
  input  logic [7:0]        bin_threshold,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [7:0]        post_img_y,
  output logic              post_img_bit,
  output logic [X_W-1:0]    post_pixel_x,
  output logic [Y_W-1:0]    post_pixel_y
);

  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    if (v >= X_W'(IMG_W - 1)) return v;
    return v + X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    if (v >= Y_W'(IMG_H - 1)) return v;
    return v + Y_W'(1);
  endfunction

  sync_t                  w_sync_p0;
  sync_t                  w_sync_p1;
  sync_t                  w_sync_p2;
  sync_t                  w_sync_p3;
  logic [15:0]            w_sum_p2;
  logic [7:0]             w_y_p2;
  logic [7:0]             w_unused_sum_lo;
  logic                   w_thr_load;
  logic                   w_vs_rise_p2;
  logic                   w_hs_fall_p2;

  // Index 0 is the p1 tap, STAGES-1 the output tap.
  sync_t [STAGES-1:0]     r_sync_dly;
  logic  [7:0]            r_thr;
  logic  [X_W-1:0]        r_col;
  logic  [Y_W-1:0]        r_row;
  logic  [7:0]            r_y_p3;
  logic                   r_bit_p3;
  logic  [X_W-1:0]        r_x_p3;
  logic  [Y_W-1:0]        r_yc_p3;

  assign w_sync_p0 = '{vsync: pre_frame_vsync, href: pre_frame_href, clken: pre_frame_clken};
  assign w_sync_p1 = r_sync_dly[0];
  assign w_sync_p2 = r_sync_dly[1];
  assign w_sync_p3 = r_sync_dly[STAGES-1];

  rgb565_to_y u_to_y (
    .i_clk    (cam_pclk),
    .i_rst_n  (rst_n),
    .i_vld_p0 (pre_frame_clken),
    .i_vld_p1 (w_sync_p1.clken),
    .i_pix_p0 (pre_img_data),
    .o_sum_p2 (w_sum_p2)
  );

  assign w_y_p2          = w_sum_p2[15:8];
  assign w_unused_sum_lo = w_sum_p2[7:0];

  // The p1 vsync tap doubles as the edge detector for threshold capture.
  assign w_thr_load   = pre_frame_vsync & ~w_sync_p1.vsync;

  // Counter events are taken at p2 so each pixel sees the counters of its own line.
  assign w_vs_rise_p2 = w_sync_p2.vsync & ~w_sync_p3.vsync;
  assign w_hs_fall_p2 = w_sync_p3.href  & ~w_sync_p2.href;

  // ---- stage p0 -> p1 -> p2 -> p3: strobe delay line and threshold latch ----
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      r_sync_dly <= '0;
      r_thr      <= '0;
    end else begin
      r_sync_dly <= {r_sync_dly[STAGES-2:0], w_sync_p0};
      if (w_thr_load) r_thr <= bin_threshold;
    end
  end

  // ---- coordinate counters (advance at the p2 -> p3 boundary) ----
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (!w_sync_p2.href)      r_col <= '0;
      else if (w_sync_p2.clken) r_col <= sat_inc_x(r_col);

      // Frame start beats a coincident line end, so a new frame always starts at row 0.
      if (w_vs_rise_p2)         r_row <= '0;
      else if (w_hs_fall_p2)    r_row <= sat_inc_y(r_row);
    end
  end

  // ---- stage p2 -> p3: luma, bit and coordinates ----
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      r_y_p3   <= '0;
      r_bit_p3 <= 1'b0;
      r_x_p3   <= '0;
      r_yc_p3  <= '0;
    end else if (w_sync_p2.clken) begin
      r_y_p3   <= w_y_p2;
      r_bit_p3 <= (w_y_p2 > r_thr);
      r_x_p3   <= r_col;
      r_yc_p3  <= r_row;
    end
  end

  assign post_frame_vsync = w_sync_p3.vsync;
  assign post_frame_href  = w_sync_p3.href;
  assign post_frame_clken = w_sync_p3.clken;
  assign post_img_y       = r_y_p3;
  assign post_img_bit     = r_bit_p3;
  assign post_pixel_x     = r_x_p3;
  assign post_pixel_y     = r_yc_p3;

endmodule
